vga_switch_sequencer: RTL and testbench

- Synthesisable successor to the bench-side switch stimulus: drives the SW_WIDTH-bit `switch` select into the VGA pattern generator.
- Steps the select through a run-time mode sequence: hold, binary count, Gray count or walking-one.
- Changes are applied only on frame boundaries, so a displayed frame is never torn.
- Dwell time is counted in frames, not cycles. A manual load path allows direct selection.

---
 rtl/vga_switch_sequencer.sv | 116 +++++++++++
 tb/tb_vga_switch_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_switch_sequencer.sv
// Frame-synchronous pattern-select sequencer for the VGA pattern generator.
// Modes: hold, binary count, Gray count, walking-one; dwell counted in frames.
module vga_switch_sequencer #(
    parameter int SW_WIDTH     = 2,
    parameter int DWELL_FRAMES = 60,
    parameter int FC_WIDTH     = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic                frame_start,
    input  logic                manual_load,
    input  logic [SW_WIDTH-1:0] manual_sw,
    output logic [SW_WIDTH-1:0] switch,
    output logic                step,
    output logic                busy
);

    localparam logic [1:0] M_HOLD = 2'b00;
    localparam logic [1:0] M_GRAY = 2'b10;
    localparam logic [1:0] M_WALK = 2'b11;

    localparam logic [SW_WIDTH-1:0] ONE      = SW_WIDTH'(1);
    localparam logic [SW_WIDTH-1:0] NPOS     = SW_WIDTH'(SW_WIDTH);
    localparam logic [SW_WIDTH-1:0] LAST_POS = SW_WIDTH'(SW_WIDTH - 1);
    localparam logic [FC_WIDTH-1:0] FC_ONE   = FC_WIDTH'(1);
    localparam logic [FC_WIDTH-1:0] DWELL_LAST = FC_WIDTH'(DWELL_FRAMES - 1);

    logic [SW_WIDTH-1:0] seq, seq_n;
    logic [1:0]          active_mode, active_mode_n;
    logic [FC_WIDTH-1:0] fcnt, fcnt_n;
    logic                pend, pend_n;
    logic [SW_WIDTH-1:0] pend_val, pend_val_n;
    logic [SW_WIDTH-1:0] switch_n;
    logic                step_n;

    function automatic logic [SW_WIDTH-1:0] remap(input logic [SW_WIDTH-1:0] s,
                                                  input logic [1:0] m);
        case (m)
            M_GRAY:  return s ^ (s >> 1);
            M_WALK:  return ONE << s;
            default: return s;
        endcase
    endfunction

    always_comb begin
        seq_n         = seq;
        active_mode_n = active_mode;
        fcnt_n        = fcnt;
        pend_n        = pend;
        pend_val_n    = pend_val;
        step_n        = 1'b0;

        if (!enable) begin
            fcnt_n = '0;
        end else if (frame_start) begin
            if (pend) begin
                seq_n         = (mode == M_WALK) ? (pend_val % NPOS) : pend_val;
                fcnt_n        = '0;
                pend_n        = 1'b0;
                step_n        = 1'b1;
                active_mode_n = mode;
            end else if (mode != active_mode) begin
                active_mode_n = mode;
                fcnt_n        = '0;
                step_n        = 1'b1;
                // walking-one position must stay a valid bit index
                if (mode == M_WALK && seq >= NPOS)
                    seq_n = '0;
            end else if (active_mode == M_HOLD) begin
                fcnt_n = '0;
            end else if (fcnt == DWELL_LAST) begin
                fcnt_n = '0;
                step_n = 1'b1;
                if (active_mode == M_WALK)
                    seq_n = (seq >= LAST_POS) ? '0 : seq + ONE;
                else
                    seq_n = seq + ONE;
            end else begin
                fcnt_n = fcnt + FC_ONE;
            end
        end

        // a load arriving with frame_start is held for the following frame
        if (manual_load) begin
            pend_n     = 1'b1;
            pend_val_n = manual_sw;
        end

        switch_n = remap(seq_n, active_mode_n);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seq         <= '0;
            active_mode <= M_HOLD;
            fcnt        <= '0;
            pend        <= 1'b0;
            pend_val    <= '0;
            switch      <= '0;
            step        <= 1'b0;
        end else begin
            seq         <= seq_n;
            active_mode <= active_mode_n;
            fcnt        <= fcnt_n;
            pend        <= pend_n;
            pend_val    <= pend_val_n;
            switch      <= switch_n;
            step        <= step_n;
        end
    end

    assign busy = pend;

endmodule

// File: tb/tb_vga_switch_sequencer.sv
// Directed bench for vga_switch_sequencer (SW_WIDTH=2, DWELL_FRAMES=3).
module tb_vga_switch_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [1:0] mode;
    logic       frame_start;
    logic       manual_load;
    logic [1:0] manual_sw;
    logic [1:0] switch;
    logic       step;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [1:0] gray_tab [4] = '{2'd0, 2'd1, 2'd3, 2'd2};

    vga_switch_sequencer #(.SW_WIDTH(2), .DWELL_FRAMES(3), .FC_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
        .frame_start(frame_start), .manual_load(manual_load), .manual_sw(manual_sw),
        .switch(switch), .step(step), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame_start pulse; checks switch/step after the sampling edge and
    // that step drops the cycle after. manual_load is cleared with the pulse.
    task automatic frame(input logic [1:0] esw, input logic estep, input string tag);
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        manual_load = 1'b0;
        chk({6'd0, switch}, {6'd0, esw}, {tag, " switch"});
        chk({7'd0, step}, {7'd0, estep}, {tag, " step"});
        @(posedge clock); #1;
        chk({7'd0, step}, 8'd0, {tag, " step_fall"});
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [1:0] v);
        manual_sw   = v;
        manual_load = 1'b1;
        @(posedge clock); #1;
        manual_load = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; mode = 2'b01;
        frame_start = 1'b0; manual_load = 1'b0; manual_sw = 2'd0;
        repeat (3) @(posedge clock);
        #1;
        chk({6'd0, switch}, 8'd0, "reset switch");
        chk({7'd0, step}, 8'd0, "reset step");
        chk({7'd0, busy}, 8'd0, "reset busy");
        reset_n = 1'b1;
        @(posedge clock); #1;

        // binary: first pulse is the 00->01 mode change, then 3 frames per value
        for (int i = 0; i < 13; i++)
            frame(2'((i / 3) % 4), (i % 3) == 0, $sformatf("bin%0d", i));

        mode = 2'b10;
        for (int i = 0; i < 13; i++)
            frame(gray_tab[(i / 3) % 4], (i % 3) == 0, $sformatf("gray%0d", i));

        mode = 2'b11;
        for (int i = 0; i < 12; i++)
            frame(((i / 3) % 2) == 0 ? 2'd1 : 2'd2, (i % 3) == 0, $sformatf("walk%0d", i));

        // manual load mid-dwell in binary mode (seq=1 carried over)
        mode = 2'b01;
        frame(2'd1, 1'b1, "man_chg");
        frame(2'd1, 1'b0, "man_f1");
        load(2'd2);
        chk({7'd0, busy}, 8'd1, "man busy");
        repeat (3) @(posedge clock);
        #1;
        chk({7'd0, busy}, 8'd1, "man busy hold");
        frame(2'd2, 1'b1, "man_apply");
        chk({7'd0, busy}, 8'd0, "man busy clr");
        frame(2'd2, 1'b0, "man_d1");
        frame(2'd2, 1'b0, "man_d2");
        frame(2'd3, 1'b1, "man_adv");

        // 01 -> 11 with seq=3 forces seq=0; then hold freezes
        mode = 2'b11;
        frame(2'd1, 1'b1, "force0");
        mode = 2'b00;
        frame(2'd0, 1'b1, "hold_chg");
        for (int i = 0; i < 4; i++)
            frame(2'd0, 1'b0, $sformatf("hold%0d", i));

        // enable=0 mid-dwell clears the dwell count
        mode = 2'b01;
        frame(2'd0, 1'b1, "en_chg");
        frame(2'd0, 1'b0, "en_f1");
        enable = 1'b0;
        for (int i = 0; i < 5; i++)
            frame(2'd0, 1'b0, $sformatf("dis%0d", i));
        enable = 1'b1;
        frame(2'd0, 1'b0, "en_r1");
        frame(2'd0, 1'b0, "en_r2");
        frame(2'd1, 1'b1, "en_adv");

        // load while disabled is kept and applied once enabled
        enable = 1'b0;
        load(2'd3);
        frame(2'd1, 1'b0, "dis_load");
        chk({7'd0, busy}, 8'd1, "dis busy");
        enable = 1'b1;
        frame(2'd3, 1'b1, "en_load");

        // load coinciding with frame_start waits one frame
        manual_sw = 2'd1;
        manual_load = 1'b1;
        frame(2'd3, 1'b0, "simul");
        chk({7'd0, busy}, 8'd1, "simul busy");
        frame(2'd1, 1'b1, "simul_apply");

        // walking-one load reduces modulo SW_WIDTH: 3 -> position 1
        mode = 2'b11;
        load(2'd3);
        frame(2'd2, 1'b1, "walk_mod");

        // async reset with a pending load
        load(2'd1);
        chk({7'd0, busy}, 8'd1, "pre_rst busy");
        #2 reset_n = 1'b0;
        #1;
        chk({6'd0, switch}, 8'd0, "arst switch");
        chk({7'd0, busy}, 8'd0, "arst busy");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        frame(2'd1, 1'b1, "rst_chg");
        chk({7'd0, busy}, 8'd0, "rst no stale");
        frame(2'd1, 1'b0, "rst_d1");
        frame(2'd1, 1'b0, "rst_d2");
        frame(2'd2, 1'b1, "rst_adv");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
